// File: rtl/mmio_bus_controller_if.sv
// rtl/mmio_bus_controller_if.sv - CPU, RAM and device bus bundle for the MMIO controller
// master: the controller; slave: the CPU stage, RAM and device around it.
interface mmio_bus_controller_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_stall;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              dev_valid;
  logic              dev_we;
  logic [DATA_W-1:0] dev_wdata;
  logic [DATA_W-1:0] dev_rdata;
  logic              dev_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output dev_valid, dev_we, dev_wdata,
    input  dev_rdata, dev_ready
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  dev_valid, dev_we, dev_wdata,
    output dev_rdata, dev_ready
  );
endinterface

// File: rtl/mmio_bus_controller.sv
// rtl/mmio_bus_controller.sv - sequences CPU data accesses to fixed-latency RAM or the MMIO device
// Every output is registered: the comb block computes next-cycle values from the next state.
module mmio_bus_controller #(
  parameter int          DATA_W      = 32,
  parameter int unsigned DEV_ADDR    = 900000,
  parameter int          MEM_LATENCY = 2,
  parameter int          DEV_TIMEOUT = 255
) (
  input logic                  clock,
  input logic                  reset,
  mmio_bus_controller_if.master bus
);

  localparam int CNT_MAX = (MEM_LATENCY > DEV_TIMEOUT) ? MEM_LATENCY : DEV_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  MEM_LAST   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0]  DEV_LAST   = CNT_W'(DEV_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] DEV_ADDR_V = DATA_W'(DEV_ADDR);

  typedef enum logic [1:0] {IDLE, MEM, DEV, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dev_valid_q, dev_valid_d;
  logic              dev_we_q, dev_we_d;
  logic [DATA_W-1:0] dev_wdata_q, dev_wdata_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_stall_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dev_valid_q <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      cpu_stall_q <= cpu_stall_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dev_valid_q <= dev_valid_d;
      dev_we_q    <= dev_we_d;
      dev_wdata_q <= dev_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          cnt_d   = '0;
          state_d = (bus.cpu_addr == DEV_ADDR_V) ? DEV : MEM;
        end
      end
      MEM: begin
        if (cnt_q == MEM_LAST) begin
          if (!we_q) cpu_rdata_d = bus.mem_rdata;
          cpu_done_d = 1'b1;
          cnt_d      = '0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEV: begin
        // A ready seen on the final wait cycle still wins over the timeout.
        if (bus.dev_ready) begin
          if (!we_q) cpu_rdata_d = bus.dev_rdata;
          cpu_done_d = 1'b1;
          cnt_d      = '0;
          state_d    = DONE;
        end else if (cnt_q == DEV_LAST) begin
          cpu_rdata_d = '1;
          cpu_done_d  = 1'b1;
          cpu_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    cpu_stall_d = (state_d == MEM) || (state_d == DEV);
    mem_en_d    = (state_d == MEM);
    mem_we_d    = mem_en_d && we_d;
    mem_addr_d  = mem_en_d ? addr_d : '0;
    mem_wdata_d = mem_en_d ? wdata_d : '0;
    dev_valid_d = (state_d == DEV);
    dev_we_d    = dev_valid_d && we_d;
    dev_wdata_d = dev_valid_d ? wdata_d : '0;
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_stall = cpu_stall_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.dev_valid = dev_valid_q;
  assign bus.dev_we    = dev_we_q;
  assign bus.dev_wdata = dev_wdata_q;

endmodule
